posted_write_buffer: RTL and testbench

- Posted-write buffer between a single requester (CPU/controller side) and a memory bus (VRAM port).
- Writes are queued in a DEPTH-entry FIFO and acknowledged immediately, then drained to the bus in order.
- Reads are forwarded to the bus, optionally after the FIFO drains, and return bus data to the requester.
- FIFO storage is a 1-read/1-write block RAM with a registered read.

---
 rtl/posted_write_buffer.sv | 160 ++++++++++++++++
 tb/tb_posted_write_buffer.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/posted_write_buffer.sv
// Posted-write buffer: writes are queued in a block-RAM FIFO and acknowledged at once,
// then drained to the memory bus in order; reads go to the bus and return its data.
module posted_write_buffer #(
  parameter int DEPTH      = 4096,
  parameter bit STALL_READ = 1'b1
) (
  input  logic        i_clock,
  input  logic        i_reset,
  output logic        o_empty,
  output logic        o_full,
  input  logic        i_request,
  input  logic        i_rw,
  input  logic [31:0] i_address,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        o_bus_request,
  output logic        o_bus_rw,
  output logic [31:0] o_bus_address,
  output logic [31:0] o_bus_wdata,
  input  logic [31:0] i_bus_rdata,
  input  logic        i_bus_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] COUNT_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {REQ_IDLE, REQ_WAIT_READ, REQ_DONE} req_state_t;
  typedef enum logic [1:0] {BUS_IDLE, BUS_FETCH, BUS_WRITE, BUS_READ} bus_state_t;

  req_state_t  req_state;
  bus_state_t  bus_state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [63:0]   mem [DEPTH];
  logic [63:0]   ram_rdata;
  logic [31:0]   read_address;

  logic pop;
  logic push;
  logic space;
  logic read_go;

  // A write can enter a full FIFO when the bus retires the head on the same edge.
  assign pop     = (bus_state == BUS_WRITE) && i_bus_ready;
  assign space   = (count != COUNT_FULL) || pop;
  assign push    = (req_state == REQ_IDLE) && i_request && i_rw && space;
  assign read_go = (req_state == REQ_WAIT_READ) && (!STALL_READ || (count == '0));

  always_ff @(posedge i_clock) begin
    if (push) begin
      mem[wr_ptr] <= {i_address, i_wdata};
    end
    ram_rdata <= mem[rd_ptr];
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      o_empty <= 1'b1;
      o_full  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      o_empty <= (count == '0);
      o_full  <= (count == COUNT_FULL);
    end
  end

  // DONE waits for the requester to release i_request so a held request is not taken twice.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      req_state    <= REQ_IDLE;
      o_ready      <= 1'b0;
      o_rdata      <= '0;
      read_address <= '0;
    end else begin
      o_ready <= 1'b0;
      case (req_state)
        REQ_IDLE: begin
          if (i_request) begin
            if (i_rw) begin
              if (space) begin
                o_ready   <= 1'b1;
                req_state <= REQ_DONE;
              end
            end else begin
              read_address <= i_address;
              req_state    <= REQ_WAIT_READ;
            end
          end
        end
        REQ_WAIT_READ: begin
          if ((bus_state == BUS_READ) && i_bus_ready) begin
            o_rdata   <= i_bus_rdata;
            o_ready   <= 1'b1;
            req_state <= REQ_DONE;
          end
        end
        REQ_DONE: begin
          if (!i_request) begin
            req_state <= REQ_IDLE;
          end
        end
        default: req_state <= REQ_IDLE;
      endcase
    end
  end

  // BUS_FETCH covers the registered RAM read of the FIFO head before the write is driven.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      bus_state     <= BUS_IDLE;
      o_bus_request <= 1'b0;
      o_bus_rw      <= 1'b0;
      o_bus_address <= '0;
      o_bus_wdata   <= '0;
    end else begin
      case (bus_state)
        BUS_IDLE: begin
          if (read_go) begin
            o_bus_request <= 1'b1;
            o_bus_rw      <= 1'b0;
            o_bus_address <= read_address;
            bus_state     <= BUS_READ;
          end else if (count != '0) begin
            bus_state <= BUS_FETCH;
          end
        end
        BUS_FETCH: begin
          o_bus_request <= 1'b1;
          o_bus_rw      <= 1'b1;
          o_bus_address <= ram_rdata[63:32];
          o_bus_wdata   <= ram_rdata[31:0];
          bus_state     <= BUS_WRITE;
        end
        BUS_WRITE, BUS_READ: begin
          if (i_bus_ready) begin
            o_bus_request <= 1'b0;
            bus_state     <= BUS_IDLE;
          end
        end
        default: bus_state <= BUS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_posted_write_buffer.sv
// Self-checking bench for posted_write_buffer: a bus responder logs every completed bus
// transaction, and the log is compared with the requester's program order.
module tb_posted_write_buffer;

  localparam int DEPTH = 16;

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic        i_clock;
  logic        i_reset;
  logic        o_empty;
  logic        o_full;
  logic        i_request;
  logic        i_rw;
  logic [31:0] i_address;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;
  logic        o_ready;
  logic        o_bus_request;
  logic        o_bus_rw;
  logic [31:0] o_bus_address;
  logic [31:0] o_bus_wdata;
  logic [31:0] i_bus_rdata;
  logic        i_bus_ready;

  int   checks;
  int   errors;
  txn_t exp_q[$];
  int   checked_upto;

  bit          bus_free;
  int          grant_target;
  int          bus_delay;
  logic [31:0] read_return;

  txn_t log_q[$];
  int   grants_done;
  int   unstable_count;
  txn_t resp_txn;
  int   resp_delay;
  bit   resp_aborted;

  posted_write_buffer #(.DEPTH(DEPTH), .STALL_READ(1'b1)) dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .o_empty      (o_empty),
    .o_full       (o_full),
    .i_request    (i_request),
    .i_rw         (i_rw),
    .i_address    (i_address),
    .i_wdata      (i_wdata),
    .o_rdata      (o_rdata),
    .o_ready      (o_ready),
    .o_bus_request(o_bus_request),
    .o_bus_rw     (o_bus_rw),
    .o_bus_address(o_bus_address),
    .o_bus_wdata  (o_bus_wdata),
    .i_bus_rdata  (i_bus_rdata),
    .i_bus_ready  (i_bus_ready)
  );

  initial begin
    i_clock = 1'b0;
    forever #5 i_clock = ~i_clock;
  end

  // Bus slave: answers a held request after bus_delay cycles unless the bus is held off.
  initial begin
    i_bus_ready    = 1'b0;
    i_bus_rdata    = '0;
    grants_done    = 0;
    unstable_count = 0;
    forever begin
      @(negedge i_clock);
      if (o_bus_request && (bus_free || grants_done < grant_target)) begin
        resp_txn.rw   = o_bus_rw;
        resp_txn.addr = o_bus_address;
        resp_txn.data = o_bus_wdata;
        resp_delay    = bus_delay;
        resp_aborted  = 1'b0;
        for (int k = 0; k < resp_delay; k++) begin
          @(negedge i_clock);
          if (!o_bus_request) begin
            resp_aborted = 1'b1;
            break;
          end
          if (o_bus_rw !== resp_txn.rw || o_bus_address !== resp_txn.addr ||
              (resp_txn.rw && o_bus_wdata !== resp_txn.data))
            unstable_count++;
        end
        if (!resp_aborted) begin
          if (!resp_txn.rw) resp_txn.data = read_return;
          i_bus_ready = 1'b1;
          i_bus_rdata = resp_txn.rw ? $urandom : read_return;
          log_q.push_back(resp_txn);
          grants_done++;
          @(negedge i_clock);
          i_bus_ready = 1'b0;
          i_bus_rdata = $urandom;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Drives one request and holds it until o_ready (latency -1 on timeout), then releases it.
  task automatic applyStimulus(input logic rw, input logic [31:0] addr,
                               input logic [31:0] data, output int latency);
    @(negedge i_clock);
    i_request = 1'b1;
    i_rw      = rw;
    i_address = addr;
    i_wdata   = data;
    latency   = -1;
    for (int c = 0; c < 400; c++) begin
      @(posedge i_clock);
      #1;
      if (o_ready) begin
        latency = c;
        break;
      end
    end
    @(negedge i_clock);
    i_request = 1'b0;
  endtask

  task automatic pushWrite(input logic [31:0] addr, input logic [31:0] data);
    txn_t t;
    int   lat;
    t.rw = 1'b1;
    t.addr = addr;
    t.data = data;
    applyStimulus(1'b1, addr, data, lat);
    checkOutput("write_ack_latency", lat, 0);
    exp_q.push_back(t);
  endtask

  task automatic doRead(input logic [31:0] addr, input logic [31:0] value);
    txn_t t;
    int   lat;
    t.rw = 1'b0;
    t.addr = addr;
    t.data = value;
    read_return = value;
    applyStimulus(1'b0, addr, 32'h0, lat);
    checkOutput("read_ack_seen", lat >= 0, 1'b1);
    checkOutput("read_rdata", o_rdata, value);
    exp_q.push_back(t);
  endtask

  task automatic waitDrain();
    for (int c = 0; c < 3000; c++) begin
      @(posedge i_clock);
      #1;
      if (log_q.size() >= exp_q.size() && o_empty && !o_bus_request) break;
    end
    checkOutput("bus_log_size", log_q.size(), exp_q.size());
    for (int i = checked_upto; i < exp_q.size() && i < log_q.size(); i++) begin
      checkOutput($sformatf("bus_rw[%0d]", i), log_q[i].rw, exp_q[i].rw);
      checkOutput($sformatf("bus_addr[%0d]", i), log_q[i].addr, exp_q[i].addr);
      checkOutput($sformatf("bus_data[%0d]", i), log_q[i].data, exp_q[i].data);
    end
    checked_upto = exp_q.size();
    checkOutput("drained_empty", o_empty, 1'b1);
  endtask

  initial begin
    int          lat;
    int          hits;
    int          log_before;
    logic [31:0] a;
    logic [31:0] d;

    checks = 0;
    errors = 0;
    checked_upto = 0;
    bus_free = 1'b1;
    grant_target = 0;
    bus_delay = 0;
    read_return = '0;
    i_reset = 1'b1;
    i_request = 1'b0;
    i_rw = 1'b0;
    i_address = '0;
    i_wdata = '0;

    repeat (3) @(posedge i_clock);
    @(negedge i_clock);
    checkOutput("reset_empty", o_empty, 1'b1);
    checkOutput("reset_full", o_full, 1'b0);
    checkOutput("reset_ready", o_ready, 1'b0);
    checkOutput("reset_rdata", o_rdata, 32'h0);
    checkOutput("reset_bus_request", o_bus_request, 1'b0);
    checkOutput("reset_bus_rw", o_bus_rw, 1'b0);
    checkOutput("reset_bus_address", o_bus_address, 32'h0);
    checkOutput("reset_bus_wdata", o_bus_wdata, 32'h0);
    i_reset = 1'b0;

    $display("[TB] single write");
    bus_delay = 3;
    pushWrite(32'h10, 32'h1234_5678);
    @(posedge i_clock);
    #1;
    checkOutput("ready_pulse_width", o_ready, 1'b0);
    waitDrain();

    $display("[TB] burst of 8 writes");
    bus_delay = 5;
    for (int i = 0; i < 8; i++) pushWrite(32'(i * 4), $urandom);
    waitDrain();

    $display("[TB] stalled read behind 3 writes");
    bus_delay = 4;
    for (int i = 0; i < 3; i++) pushWrite($urandom, $urandom);
    doRead(32'h40, 32'hCAFE_BABE);
    pushWrite(32'h44, 32'h5555_AAAA);
    checkOutput("rdata_held_after_write", o_rdata, 32'hCAFE_BABE);
    waitDrain();

    $display("[TB] random mix");
    for (int i = 0; i < 30; i++) begin
      bus_delay = $urandom_range(0, 4);
      a = $urandom;
      d = $urandom;
      if ($urandom_range(0, 3) != 0) pushWrite(a, d);
      else doRead(a, d);
    end
    waitDrain();

    $display("[TB] fill to full");
    bus_free = 1'b0;
    grant_target = grants_done;
    bus_delay = 0;
    for (int i = 0; i < DEPTH; i++) pushWrite(32'h1000 + 32'(i * 4), $urandom);
    repeat (2) @(posedge i_clock);
    #1;
    checkOutput("full_flag", o_full, 1'b1);
    a = 32'h2000;
    d = $urandom;
    @(negedge i_clock);
    i_request = 1'b1;
    i_rw = 1'b1;
    i_address = a;
    i_wdata = d;
    hits = 0;
    repeat (6) begin
      @(posedge i_clock);
      #1;
      if (o_ready) hits++;
    end
    checkOutput("full_no_ack", hits, 0);
    grant_target = grants_done + 1;
    lat = -1;
    for (int c = 0; c < 50; c++) begin
      @(posedge i_clock);
      #1;
      if (o_ready) begin
        lat = c;
        break;
      end
    end
    checkOutput("full_ack_after_pop", lat >= 0, 1'b1);
    @(negedge i_clock);
    i_request = 1'b0;
    exp_q.push_back('{rw: 1'b1, addr: a, data: d});
    repeat (4) @(posedge i_clock);
    #1;
    checkOutput("full_after_swap", o_full, 1'b1);
    checkOutput("one_pop_only", grants_done, grant_target);
    bus_free = 1'b1;
    waitDrain();
    checkOutput("full_cleared", o_full, 1'b0);

    $display("[TB] held request");
    bus_delay = 2;
    a = 32'h300;
    d = $urandom;
    @(negedge i_clock);
    i_request = 1'b1;
    i_rw = 1'b1;
    i_address = a;
    i_wdata = d;
    lat = -1;
    for (int c = 0; c < 20; c++) begin
      @(posedge i_clock);
      #1;
      if (o_ready) begin
        lat = c;
        break;
      end
    end
    checkOutput("held_first_ack", lat, 0);
    exp_q.push_back('{rw: 1'b1, addr: a, data: d});
    hits = 0;
    repeat (6) begin
      @(posedge i_clock);
      #1;
      if (o_ready) hits++;
    end
    checkOutput("held_no_second_ack", hits, 0);
    @(negedge i_clock);
    i_request = 1'b0;
    repeat (2) @(posedge i_clock);
    pushWrite(32'h304, $urandom);
    waitDrain();

    $display("[TB] reset with queued writes");
    bus_free = 1'b0;
    grant_target = grants_done;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h4000 + 32'(i * 4), $urandom, lat);
      checkOutput("pre_reset_ack", lat, 0);
    end
    repeat (3) @(posedge i_clock);
    #1;
    checkOutput("pre_reset_bus_busy", o_bus_request, 1'b1);
    checkOutput("pre_reset_not_empty", o_empty, 1'b0);
    log_before = log_q.size();
    @(negedge i_clock);
    i_reset = 1'b1;
    @(posedge i_clock);
    #1;
    checkOutput("reset_drops_bus_request", o_bus_request, 1'b0);
    checkOutput("reset_sets_empty", o_empty, 1'b1);
    @(negedge i_clock);
    i_reset = 1'b0;
    bus_free = 1'b1;
    repeat (40) @(posedge i_clock);
    #1;
    checkOutput("no_writes_after_reset", log_q.size(), log_before);
    checkOutput("bus_idle_after_reset", o_bus_request, 1'b0);
    checkOutput("empty_after_reset", o_empty, 1'b1);
    checkOutput("bus_stable_while_requested", unstable_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
